// File: rtl/apb5_completer_if.sv
// APB5 bus bundle between a requester and one completer select line.
// The master modport drives the request side and the slave modport drives the response side.
interface apb5_completer_if #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int USER_REQ_WIDTH  = 8,
   parameter int USER_DATA_WIDTH = DATA_WIDTH / 2,
   parameter int USER_RESP_WIDTH = 16,
   parameter int STRB_WIDTH      = DATA_WIDTH / 8
) ();
   logic                       psel;
   logic                       penable;
   logic                       pwrite;
   logic [ADDR_WIDTH-1:0]      paddr;
   logic [DATA_WIDTH-1:0]      pwdata;
   logic [STRB_WIDTH-1:0]      pstrb;
   logic [2:0]                 pprot;
   logic [USER_REQ_WIDTH-1:0]  pauser;
   logic [USER_DATA_WIDTH-1:0] pwuser;
   logic                       pparity;
   logic                       pready;
   logic                       pslverr;
   logic                       pparerr;
   logic [DATA_WIDTH-1:0]      prdata;
   logic [USER_DATA_WIDTH-1:0] pruser;
   logic [USER_RESP_WIDTH-1:0] pbuser;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, pstrb, pprot, pauser, pwuser, pparity,
      input  pready, pslverr, pparerr, prdata, pruser, pbuser
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot, pauser, pwuser, pparity,
      output pready, pslverr, pparerr, prdata, pruser, pbuser
   );
endinterface

// File: rtl/apb5_completer.sv
// APB5 register-bank completer: decodes at the setup edge, waits WAIT_CYCLES, then
// answers for one cycle; writes commit only on an error-free completion edge.
module apb5_completer #(
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    USER_REQ_WIDTH  = 8,
   parameter int                    USER_DATA_WIDTH = DATA_WIDTH / 2,
   parameter int                    USER_RESP_WIDTH = 16,
   parameter int                    STRB_WIDTH      = DATA_WIDTH / 8,
   parameter int                    NUM_REGS        = 16,
   parameter int                    WAIT_CYCLES     = 0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE        = 'hA9B5_0001
) (
   input logic              i_pclk,
   input logic              i_presetn,
   apb5_completer_if.slave  io_apb
);
   localparam int         IW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [10:0] LP_NREGS     = 11'(NUM_REGS);
   localparam logic [3:0]  LP_WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

   state_t r_state;
   state_t w_state_next;

   logic                       w_setup, w_access, w_load, w_dec, w_commit;
   logic                       w_addr_err, w_par_err, w_idx_ok, w_rd_ok;
   logic [9:0]                 w_idx;
   logic [DATA_WIDTH-1:0]      w_rd_data;
   logic [USER_DATA_WIDTH-1:0] w_rd_user;
   logic [DATA_WIDTH-1:0]      w_reg_data [NUM_REGS];
   logic [USER_DATA_WIDTH-1:0] w_reg_user [NUM_REGS];

   logic [3:0]                 r_cnt;
   logic [9:0]                 r_idx;
   logic                       r_write, r_addr_err, r_par_err;
   logic [USER_REQ_WIDTH-1:0]  r_pauser;
   logic [DATA_WIDTH-1:0]      r_rdata;
   logic [USER_DATA_WIDTH-1:0] r_ruser;

   assign w_setup  = io_apb.psel & ~io_apb.penable;
   assign w_access = io_apb.psel & io_apb.penable;
   assign w_idx    = io_apb.paddr[11:2];
   assign w_idx_ok = ({1'b0, w_idx} < LP_NREGS);

   assign w_addr_err = (io_apb.paddr[1:0] != 2'b00) | ~w_idx_ok
                     | (io_apb.pwrite & (w_idx == 10'd0))
                     | (io_apb.pwrite & ~io_apb.pprot[0]);
   assign w_par_err  = (^{io_apb.paddr, io_apb.pwrite, io_apb.pstrb, io_apb.pprot,
                          io_apb.pwdata, io_apb.pauser, io_apb.pwuser}) != io_apb.pparity;

   assign w_rd_data = w_idx_ok ? w_reg_data[w_idx[IW-1:0]] : '0;
   assign w_rd_user = w_idx_ok ? w_reg_user[w_idx[IW-1:0]] : '0;
   assign w_rd_ok   = ~r_write & ~r_addr_err & ~r_par_err;

   // A setup cycle always wins: it restarts decode even mid-transfer, dropping the old one.
   always_comb begin
      w_state_next   = r_state;
      w_load         = 1'b0;
      w_dec          = 1'b0;
      w_commit       = 1'b0;
      io_apb.pready  = 1'b0;
      io_apb.pslverr = 1'b0;
      io_apb.pparerr = 1'b0;
      io_apb.prdata  = '0;
      io_apb.pruser  = '0;
      io_apb.pbuser  = '0;
      if (w_setup) begin
         w_load       = 1'b1;
         w_state_next = (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
      end else begin
         case (r_state)
            S_WAIT: begin
               if (!io_apb.psel)       w_state_next = S_IDLE;
               else if (r_cnt == 4'd0) w_state_next = S_READY;
               else                    w_dec        = 1'b1;
            end
            S_READY: begin
               w_state_next = S_IDLE;
               w_commit     = w_access & r_write & ~r_addr_err & ~r_par_err;
            end
            default: ;
         endcase
      end
      if (r_state == S_READY) begin
         io_apb.pready  = 1'b1;
         io_apb.pslverr = r_addr_err | r_par_err;
         io_apb.pparerr = r_par_err;
         io_apb.prdata  = w_rd_ok ? r_rdata : '0;
         io_apb.pruser  = w_rd_ok ? r_ruser : '0;
         io_apb.pbuser[USER_REQ_WIDTH-1:0] = r_pauser;
         io_apb.pbuser[USER_REQ_WIDTH]     = r_par_err;
         io_apb.pbuser[USER_REQ_WIDTH+1]   = r_addr_err;
      end
   end

   always_ff @(posedge i_pclk) begin
      if (!i_presetn) r_state <= S_IDLE;
      else            r_state <= w_state_next;
   end

   always_ff @(posedge i_pclk) begin
      if (!i_presetn) begin
         r_cnt      <= '0;
         r_idx      <= '0;
         r_write    <= 1'b0;
         r_addr_err <= 1'b0;
         r_par_err  <= 1'b0;
         r_pauser   <= '0;
         r_rdata    <= '0;
         r_ruser    <= '0;
      end else if (w_load) begin
         r_cnt      <= LP_WAIT_INIT;
         r_idx      <= w_idx;
         r_write    <= io_apb.pwrite;
         r_addr_err <= w_addr_err;
         r_par_err  <= w_par_err;
         r_pauser   <= io_apb.pauser;
         r_rdata    <= w_rd_data;
         r_ruser    <= w_rd_user;
      end else if (w_dec) begin
         r_cnt      <= r_cnt - 4'd1;
      end
   end

   // Index 0 is the constant ID word; every other index is a byte-strobed register.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_id
         assign w_reg_data[gi] = ID_VALUE;
         assign w_reg_user[gi] = '0;
      end else begin : g_rw
         logic                       w_we;
         logic [DATA_WIDTH-1:0]      r_data;
         logic [USER_DATA_WIDTH-1:0] r_user;

         assign w_we = w_commit & (r_idx == 10'(gi));

         always_ff @(posedge i_pclk) begin
            if (!i_presetn) begin
               r_data <= '0;
               r_user <= '0;
            end else if (w_we) begin
               for (int b = 0; b < STRB_WIDTH; b++) begin
                  if (io_apb.pstrb[b]) r_data[8*b +: 8] <= io_apb.pwdata[8*b +: 8];
               end
               if (|io_apb.pstrb) r_user <= io_apb.pwuser;
            end
         end

         assign w_reg_data[gi] = r_data;
         assign w_reg_user[gi] = r_user;
      end
   end
endmodule

// File: tb/tb_apb5_completer.sv
// Bench for apb5_completer: two instances (0 and 3 wait states) share one request bus
// with separate select bits; a directed vector table plus reset/abort sequences.
module tb_apb5_completer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n0, rst_n1;
   logic [1:0]  psel;
   logic        penable, pwrite, pparity;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [7:0]  pauser;
   logic [15:0] pwuser;
   int          cur;

   apb5_completer_if bus0 ();
   apb5_completer_if bus1 ();

   assign bus0.psel = psel[0];   assign bus1.psel = psel[1];
   assign bus0.penable = penable; assign bus1.penable = penable;
   assign bus0.pwrite = pwrite;   assign bus1.pwrite = pwrite;
   assign bus0.paddr = paddr;     assign bus1.paddr = paddr;
   assign bus0.pwdata = pwdata;   assign bus1.pwdata = pwdata;
   assign bus0.pstrb = pstrb;     assign bus1.pstrb = pstrb;
   assign bus0.pprot = pprot;     assign bus1.pprot = pprot;
   assign bus0.pauser = pauser;   assign bus1.pauser = pauser;
   assign bus0.pwuser = pwuser;   assign bus1.pwuser = pwuser;
   assign bus0.pparity = pparity; assign bus1.pparity = pparity;

   apb5_completer #(.WAIT_CYCLES(0)) dut0 (.i_pclk(clk), .i_presetn(rst_n0), .io_apb(bus0.slave));
   apb5_completer #(.WAIT_CYCLES(3)) dut1 (.i_pclk(clk), .i_presetn(rst_n1), .io_apb(bus1.slave));

   logic        m_pready, m_pslverr, m_pparerr;
   logic [31:0] m_prdata;
   logic [15:0] m_pruser, m_pbuser;
   assign m_pready  = (cur == 1) ? bus1.pready  : bus0.pready;
   assign m_pslverr = (cur == 1) ? bus1.pslverr : bus0.pslverr;
   assign m_pparerr = (cur == 1) ? bus1.pparerr : bus0.pparerr;
   assign m_prdata  = (cur == 1) ? bus1.prdata  : bus0.prdata;
   assign m_pruser  = (cur == 1) ? bus1.pruser  : bus0.pruser;
   assign m_pbuser  = (cur == 1) ? bus1.pbuser  : bus0.pbuser;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " pready"},  m_pready,  1'b0);
      check({tag, " pslverr"}, m_pslverr, 1'b0);
      check({tag, " pparerr"}, m_pparerr, 1'b0);
      check({tag, " prdata"},  m_prdata,  32'h0);
      check({tag, " pruser"},  m_pruser,  16'h0);
      check({tag, " pbuser"},  m_pbuser,  16'h0);
   endtask

   task automatic drive_setup(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] s, input logic [2:0] p, input logic [7:0] au,
                              input logic [15:0] wu, input logic flip);
      @(negedge clk);
      cur     = d;
      psel    = (d == 1) ? 2'b10 : 2'b01;
      penable = 1'b0;
      pwrite  = wr;   paddr  = a;  pwdata = wd; pstrb = s;
      pprot   = p;    pauser = au; pwuser = wu;
      pparity = (^{a, wr, s, p, wd, au, wu}) ^ flip;
   endtask

   // Drives a full transfer and returns the response seen in the PREADY cycle.
   task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, input logic [2:0] p, input logic [7:0] au,
                       input logic [15:0] wu, input logic flip,
                       output logic [31:0] rd, output logic [15:0] ru, output logic se,
                       output logic pe, output logic [15:0] bu, output int waits);
      drive_setup(d, wr, a, wd, s, p, au, wu, flip);
      @(negedge clk);
      penable = 1'b1;
      waits   = 0;
      while (m_pready !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      rd = m_prdata; ru = m_pruser; se = m_pslverr; pe = m_pparerr; bu = m_pbuser;
   endtask

   task automatic go_idle();
      @(negedge clk);
      psel    = 2'b00;
      penable = 1'b0;
   endtask

   typedef struct {
      int          d;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      logic [7:0]  auser;
      logic [15:0] wuser;
      logic        flip;
      logic        exp_aerr;
      logic        exp_perr;
      logic [31:0] exp_rdata;
      logic [15:0] exp_ruser;
      int          exp_waits;
   } vec_t;

   vec_t vt[$];

   initial begin
      logic [31:0] rd;
      logic [15:0] ru, bu;
      logic        se, pe;
      int          waits;

      vt.push_back('{0, 1'b1, 32'h004, 32'hDEADBEEF, 4'hF, 3'b001, 8'h11, 16'h1234, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h004, 32'h0, 4'h0, 3'b001, 8'h12, 16'h0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 16'h1234, 0});
      vt.push_back('{0, 1'b1, 32'h008, 32'h11223344, 4'hF, 3'b001, 8'h13, 16'h5555, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b1, 32'h008, 32'h0000AB00, 4'b0010, 3'b001, 8'h14, 16'h6666, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h008, 32'h0, 4'h0, 3'b001, 8'h15, 16'h0, 1'b0, 1'b0, 1'b0, 32'h1122AB44, 16'h6666, 0});
      vt.push_back('{0, 1'b1, 32'h040, 32'h1, 4'hF, 3'b001, 8'h21, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b1, 32'h002, 32'h2, 4'hF, 3'b001, 8'h22, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b1, 32'h000, 32'h3, 4'hF, 3'b001, 8'h23, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h000, 32'h0, 4'h0, 3'b001, 8'h24, 16'h0, 1'b0, 1'b0, 1'b0, 32'hA9B50001, 16'h0, 0});
      vt.push_back('{0, 1'b1, 32'h00C, 32'h77, 4'hF, 3'b001, 8'h30, 16'h0101, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b1, 32'h00C, 32'h5, 4'hF, 3'b001, 8'h3C, 16'h0202, 1'b1, 1'b0, 1'b1, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h00C, 32'h0, 4'h0, 3'b001, 8'h31, 16'h0, 1'b0, 1'b0, 1'b0, 32'h77, 16'h0101, 0});
      vt.push_back('{0, 1'b1, 32'h010, 32'h99, 4'hF, 3'b000, 8'h40, 16'h0303, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h010, 32'h0, 4'h0, 3'b000, 8'h41, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b1, 32'h014, 32'hFFFFFFFF, 4'h0, 3'b001, 8'h50, 16'hAAAA, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h014, 32'h0, 4'h0, 3'b001, 8'h51, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h040, 32'h0, 4'h0, 3'b001, 8'h52, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h004, 32'h0, 4'h0, 3'b001, 8'h53, 16'h0, 1'b1, 1'b0, 1'b1, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h004, 32'h0, 4'h0, 3'b001, 8'h54, 16'h0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 16'h1234, 0});
      vt.push_back('{0, 1'b1, 32'h03C, 32'hCAFEF00D, 4'hF, 3'b011, 8'h60, 16'hBEEF, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 0});
      vt.push_back('{0, 1'b0, 32'h03C, 32'h0, 4'h0, 3'b001, 8'h61, 16'h0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 16'hBEEF, 0});
      vt.push_back('{1, 1'b0, 32'h000, 32'h0, 4'h0, 3'b001, 8'h62, 16'h0, 1'b0, 1'b0, 1'b0, 32'hA9B50001, 16'h0, 3});
      vt.push_back('{1, 1'b1, 32'h004, 32'hFFFF0000, 4'hF, 3'b001, 8'h70, 16'h0F0F, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 3});
      vt.push_back('{1, 1'b0, 32'h004, 32'h0, 4'h0, 3'b001, 8'h71, 16'h0, 1'b0, 1'b0, 1'b0, 32'hFFFF0000, 16'h0F0F, 3});

      cur = 0; psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      pstrb = '0; pprot = '0; pauser = '0; pwuser = '0; pparity = 1'b0;
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      repeat (3) @(negedge clk);
      cur = 0; check_quiet("reset dut0");
      cur = 1; check_quiet("reset dut1");
      rst_n0 = 1'b1; rst_n1 = 1'b1;

      // Back-to-back transfers: each setup immediately follows the previous completion edge.
      foreach (vt[i]) begin
         xfer(vt[i].d, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].prot,
              vt[i].auser, vt[i].wuser, vt[i].flip, rd, ru, se, pe, bu, waits);
         $display("vec %0d dut%0d %s addr=%h rdata=%h ruser=%h slverr=%b parerr=%b buser=%h waits=%0d",
                  i, vt[i].d, vt[i].wr ? "WR" : "RD", vt[i].addr, rd, ru, se, pe, bu, waits);
         check($sformatf("vec%0d waits", i), waits, vt[i].exp_waits);
         check($sformatf("vec%0d pslverr", i), se, vt[i].exp_aerr | vt[i].exp_perr);
         check($sformatf("vec%0d pparerr", i), pe, vt[i].exp_perr);
         check($sformatf("vec%0d prdata", i), rd, vt[i].exp_rdata);
         check($sformatf("vec%0d pruser", i), ru, vt[i].exp_ruser);
         check($sformatf("vec%0d pbuser", i), bu, {6'b0, vt[i].exp_aerr, vt[i].exp_perr, vt[i].auser});
      end
      go_idle();
      check("pready single cycle", m_pready, 1'b0);

      // Select dropped mid-wait: the write must be abandoned.
      drive_setup(1, 1'b1, 32'h008, 32'hA5A5A5A5, 4'hF, 3'b001, 8'h80, 16'h1111, 1'b0);
      @(negedge clk); penable = 1'b1;
      check("abort pready in wait", m_pready, 1'b0);
      go_idle();
      repeat (4) @(negedge clk);
      check("abort no late pready", m_pready, 1'b0);
      xfer(1, 1'b0, 32'h008, 32'h0, 4'h0, 3'b001, 8'h81, 16'h0, 1'b0, rd, ru, se, pe, bu, waits);
      $display("abort readback addr=008 rdata=%h ruser=%h waits=%0d", rd, ru, waits);
      check("abort readback prdata", rd, 32'h0);
      check("abort readback pruser", ru, 16'h0);
      check("abort readback waits", waits, 3);
      go_idle();

      // Reset asserted during the wait phase of a write.
      drive_setup(1, 1'b1, 32'h004, 32'h12345678, 4'hF, 3'b001, 8'h90, 16'h2222, 1'b0);
      @(negedge clk); penable = 1'b1;
      check("rst pready in wait", m_pready, 1'b0);
      rst_n1 = 1'b0;
      @(negedge clk);
      check_quiet("rst in wait");
      rst_n1 = 1'b1; psel = 2'b00; penable = 1'b0;
      @(negedge clk);
      check("rst stays idle", m_pready, 1'b0);
      xfer(1, 1'b0, 32'h004, 32'h0, 4'h0, 3'b001, 8'h91, 16'h0, 1'b0, rd, ru, se, pe, bu, waits);
      $display("post-reset readback addr=004 rdata=%h ruser=%h slverr=%b waits=%0d", rd, ru, se, waits);
      check("post-reset prdata", rd, 32'h0);
      check("post-reset pruser", ru, 16'h0);
      check("post-reset pslverr", se, 1'b0);
      check("post-reset waits", waits, 3);
      go_idle();
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
